reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_seq_timer.sv | 47 ++++
 rtl/reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: the FSM state type, the
// timer width and the default values of the sequencer parameters.
package reset_seq_pkg;

  // Width of the phase timer. All programmable lengths fit in it.
  localparam int unsigned CNT_W = 16;

  localparam int unsigned DEF_NUM_DOMAINS    = 3;
  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_STEP_CYCLES    = 8;
  localparam int unsigned DEF_READY_TIMEOUT  = 1024;
  localparam int unsigned DEF_SW_HOLD_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_HOLD,      // all domains held after rst_ni deasserts
    ST_RELEASE,   // release domain idx (one cycle)
    ST_WAIT_RDY,  // wait for domain_ready_i[idx] or the timeout
    ST_STEP,      // gap before the next domain is released
    ST_RUN,       // every domain released, sequence complete
    ST_SW_RST     // software-requested hold of all domains
  } state_e;

endpackage

// File: rtl/reset_seq_timer.sv
// Phase timer for the reset sequencer.
// A 16-bit up-counter cleared by clr_i and otherwise incremented every cycle,
// saturating at all-ones so a long stay in one state never wraps.
// done_o is high once the counter has seen limit_i cycles since the last clear,
// i.e. on the limit_i-th rising edge after the clearing edge.
//   clk_i    : system clock, rising edge
//   rst_ni   : asynchronous active-low reset, clears the counter
//   clr_i    : synchronous clear (asserted on every FSM state change)
//   limit_i  : cycle count to reach, must be >= 1
//   done_o   : count reached (greater-or-equal compare, stays high)
module reset_seq_timer
  import reset_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: clocked state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q >= (limit_i - CNT_W'(1)));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for NUM_DOMAINS downstream domains.
// After rst_ni deasserts all domains are held for HOLD_CYCLES, then released
// one at a time in index order. Each released domain is given up to
// READY_TIMEOUT cycles to report domain_ready_i; a miss sets the sticky
// timeout_err_o and the sequence continues anyway. STEP_CYCLES separate a
// ready from the next release. A rising edge on sw_rst_req_i outside HOLD and
// SW_RST puts every domain back into reset for SW_HOLD_CYCLES and restarts.
//   clk_i          : system clock, rising edge
//   rst_ni         : asynchronous active-low reset (deassertion pre-synchronised)
//   sw_rst_req_i   : software reset request, level or pulse, edge-detected
//   domain_ready_i : per-domain initialised indication
//   domain_rst_no  : per-domain active-low reset, registered
//   seq_done_o     : high in RUN (all domains released)
//   busy_o         : high in every state except RUN
//   timeout_err_o  : sticky, a domain missed its ready timeout
//   stage_o        : index of the domain currently being sequenced
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned STEP_CYCLES    = DEF_STEP_CYCLES,
  parameter int unsigned READY_TIMEOUT  = DEF_READY_TIMEOUT,
  parameter int unsigned SW_HOLD_CYCLES = DEF_SW_HOLD_CYCLES,
  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sw_rst_req_i,
  input  logic [NUM_DOMAINS-1:0] domain_ready_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_no,
  output logic                   seq_done_o,
  output logic                   busy_o,
  output logic                   timeout_err_o,
  output logic [IDX_W-1:0]       stage_o
);

  localparam logic [CNT_W-1:0] HOLD_LIM    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STEP_LIM    = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(READY_TIMEOUT);
  localparam logic [CNT_W-1:0] SW_HOLD_LIM = CNT_W'(SW_HOLD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DOMAINS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
  logic                   timeout_q, timeout_d;
  logic                   sw_prev_q;

  logic                   sw_rise;
  logic                   tmr_clr;
  logic [CNT_W-1:0]       tmr_limit;
  logic                   tmr_done;

  // A held request produces exactly one rise, so it triggers only once.
  assign sw_rise = sw_rst_req_i & ~sw_prev_q;

  // Restart the timer whenever the state changes, so each state counts
  // from zero on entry.
  assign tmr_clr = (state_d != state_q);

  always_comb begin
    tmr_limit = CNT_W'(1);
    case (state_q)
      ST_HOLD:     tmr_limit = HOLD_LIM;
      ST_WAIT_RDY: tmr_limit = TIMEOUT_LIM;
      ST_STEP:     tmr_limit = STEP_LIM;
      ST_SW_RST:   tmr_limit = SW_HOLD_LIM;
      default:     tmr_limit = CNT_W'(1);
    endcase
  end

  reset_seq_timer u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (tmr_clr),
    .limit_i (tmr_limit),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dom_rst_n_d = dom_rst_n_q;
    timeout_d   = timeout_q;

    // Requests in HOLD and SW_RST fall through to the per-state logic and
    // are dropped; in all other states a rise wins over ready or timeout.
    if (sw_rise && (state_q != ST_HOLD) && (state_q != ST_SW_RST)) begin
      state_d     = ST_SW_RST;
      idx_d       = '0;
      dom_rst_n_d = '0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (tmr_done) begin
            state_d = ST_RELEASE;
            idx_d   = '0;
          end
        end
        ST_RELEASE: begin
          dom_rst_n_d[idx_q] = 1'b1;
          state_d            = ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (domain_ready_i[idx_q] || tmr_done) begin
            // Timeout only counts when ready is still missing on that edge.
            if (!domain_ready_i[idx_q]) begin
              timeout_d = 1'b1;
            end
            state_d = (idx_q == LAST_IDX) ? ST_RUN : ST_STEP;
          end
        end
        ST_STEP: begin
          if (tmr_done) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        ST_SW_RST: begin
          if (tmr_done) begin
            state_d = ST_RELEASE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d     = ST_HOLD;
          idx_d       = '0;
          dom_rst_n_d = '0;
        end
      endcase
    end
  end

  // The asynchronous clear puts every domain back into reset the moment
  // rst_ni falls, whatever the sequence was doing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HOLD;
      idx_q       <= '0;
      dom_rst_n_q <= '0;
      timeout_q   <= 1'b0;
      sw_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dom_rst_n_q <= dom_rst_n_d;
      timeout_q   <= timeout_d;
      sw_prev_q   <= sw_rst_req_i;
    end
  end

  assign domain_rst_no = dom_rst_n_q;
  assign seq_done_o    = (state_q == ST_RUN);
  assign busy_o        = (state_q != ST_RUN);
  assign timeout_err_o = timeout_q;
  assign stage_o       = idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (3 domains, HOLD=16, STEP=8,
// TIMEOUT=64, SW_HOLD=16). Edges are numbered from the edge that starts a
// sequence (edge 0: rst_ni deassertion point or the edge sampling a software
// request). The reference model computes release, timeout and done edges
// from the rules: release_0 = hold+1, each domain waits w cycles
// (w = ready latency, capped at TIMEOUT, at least 1), then STEP+1 cycles to
// the next release; RUN is reached w cycles after the last release.
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int H    = 16;
  localparam int S    = 8;
  localparam int T    = 64;
  localparam int SWH  = 16;
  localparam int NEVER = 1000;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         sw_rst_req_i = 1'b0;
  logic [N-1:0] domain_ready_i = '0;
  logic [N-1:0] domain_rst_no;
  logic         seq_done_o;
  logic         busy_o;
  logic         timeout_err_o;
  logic [1:0]   stage_o;

  int errors = 0;
  int checks = 0;

  always #10 clk_i = ~clk_i;

  reset_sequencer #(
    .NUM_DOMAINS    (N),
    .HOLD_CYCLES    (H),
    .STEP_CYCLES    (S),
    .READY_TIMEOUT  (T),
    .SW_HOLD_CYCLES (SWH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sw_rst_req_i   (sw_rst_req_i),
    .domain_ready_i (domain_ready_i),
    .domain_rst_no  (domain_rst_no),
    .seq_done_o     (seq_done_o),
    .busy_o         (busy_o),
    .timeout_err_o  (timeout_err_o),
    .stage_o        (stage_o)
  );

  // Runs one full sequence starting after edge 0 and compares it with the
  // model. d[k] = 0: ready tied high; otherwise ready[k] is first sampled high
  // d[k] edges after domain k's release (>T means never in time).
  // sw_rst_req_i is high on the edges numbered sw_from..sw_to.
  task automatic run_seq(input string name, input int hold,
                         input int d0, input int d1, input int d2,
                         input int sw_from, input int sw_to);
    int d [N];
    int rel_exp [N];
    int rel_obs [N];
    int t, w, to_exp, to_obs, done_exp, done_obs, limit;
    int drops, stage_bad, busy_bad;
    logic [N-1:0] prev;
    d = '{d0, d1, d2};
    to_exp = -1;
    to_obs = -1;
    done_obs = -1;
    drops = 0;
    stage_bad = 0;
    busy_bad = 0;
    t = hold + 1;
    done_exp = 0;
    for (int k = 0; k < N; k++) begin
      rel_exp[k] = t;
      rel_obs[k] = -1;
      w = (d[k] == 0) ? 1 : ((d[k] < T) ? d[k] : T);
      if (d[k] > T && to_exp < 0) to_exp = t + T;
      if (k == N - 1) done_exp = t + w;
      else t = t + w + S + 1;
    end
    limit = done_exp + 4;
    prev = domain_rst_no;
    for (int n = 1; n <= limit; n++) begin
      sw_rst_req_i = (n >= sw_from) && (n <= sw_to);
      for (int k = 0; k < N; k++)
        domain_ready_i[k] = (d[k] == 0) || (rel_obs[k] >= 0 && (n - rel_obs[k]) >= d[k]);
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N; k++) begin
        if (domain_rst_no[k] === 1'b1 && prev[k] !== 1'b1 && rel_obs[k] < 0) begin
          rel_obs[k] = n;
          if (stage_o !== k[1:0]) stage_bad++;
        end
      end
      if ((prev & ~domain_rst_no) != '0) drops++;
      if (timeout_err_o === 1'b1 && to_obs < 0) to_obs = n;
      if (seq_done_o === 1'b1 && done_obs < 0) done_obs = n;
      if (busy_o !== ~seq_done_o) busy_bad++;
      prev = domain_rst_no;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (rel_obs[k] !== rel_exp[k]) begin
        errors++;
        $display("FAIL %s release_edge[%0d]: got %0d expected %0d", name, k, rel_obs[k], rel_exp[k]);
      end
    end
    checks++;
    if (to_obs !== to_exp) begin
      errors++;
      $display("FAIL %s timeout_edge: got %0d expected %0d", name, to_obs, to_exp);
    end
    checks++;
    if (done_obs !== done_exp) begin
      errors++;
      $display("FAIL %s done_edge: got %0d expected %0d", name, done_obs, done_exp);
    end
    checks++;
    if (drops != 0 || stage_bad != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL %s drops/stage/busy: got %0d/%0d/%0d expected 0/0/0", name, drops, stage_bad, busy_bad);
    end
    checks++;
    if (domain_rst_no !== 3'b111 || stage_o !== 2'd2 || timeout_err_o !== (to_exp >= 0)) begin
      errors++;
      $display("FAIL %s end_state: got rst_n=%b stage=%0d to=%b expected 111/2/%0d",
               name, domain_rst_no, stage_o, timeout_err_o, (to_exp >= 0));
    end
  endtask

  // Generates a fresh rising edge on sw_rst_req_i; the sampling edge is
  // edge 0 of the new sequence. Request is left high for run_seq to drive.
  task automatic sw_start(input string name);
    sw_rst_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    sw_rst_req_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (domain_rst_no !== 3'b000 || timeout_err_o !== 1'b0) begin
      errors++;
      $display("FAIL %s sw_entry: got rst_n=%b to=%b expected 000/0", name, domain_rst_no, timeout_err_o);
    end
    checks++;
    if (seq_done_o !== 1'b0 || busy_o !== 1'b1 || stage_o !== 2'd0) begin
      errors++;
      $display("FAIL %s sw_entry_status: got done=%b busy=%b stage=%0d expected 0/1/0",
               name, seq_done_o, busy_o, stage_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (domain_rst_no !== 3'b000 || seq_done_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got rst_n=%b done=%b busy=%b expected 000/0/1", domain_rst_no, seq_done_o, busy_o);
    end
    checks++;
    if (timeout_err_o !== 1'b0 || stage_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_flags: got to=%b stage=%0d expected 0/0", timeout_err_o, stage_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_power_up();
    run_seq("power_up", H, 0, 0, 0, 1, 0);
  endtask

  task automatic test_ready_delay();
    sw_start("ready_delay");
    run_seq("ready_delay", SWH, 0, 21, 0, 1, 0);
  endtask

  task automatic test_timeout();
    sw_start("timeout");
    run_seq("timeout", SWH, NEVER, 0, 0, 1, 0);
    sw_start("timeout_at_limit");
    run_seq("timeout_at_limit", SWH, 1, T, 0, 1, 0);
    sw_start("timeout_past_limit");
    run_seq("timeout_past_limit", SWH, 1, 0, T + 1, 1, 0);
  endtask

  task automatic test_sw_reset();
    sw_start("sw_pulse1");
    run_seq("sw_pulse1", SWH, 0, 0, 0, 1, 0);
    sw_start("sw_pulse10");
    run_seq("sw_pulse10", SWH, 0, 0, 0, 1, 9);
    sw_start("sw_held");
    run_seq("sw_held", SWH, 0, 0, 0, 1, 100000);
    sw_start("sw_in_sw_rst");
    run_seq("sw_in_sw_rst", SWH, 0, 0, 0, 5, 7);
  endtask

  // Software request on the same edge as a ready (or a timeout) for domain 0.
  task automatic test_sw_wins(input bit use_timeout);
    int coll;
    string name;
    name = use_timeout ? "sw_vs_timeout" : "sw_vs_ready";
    coll = SWH + 1 + (use_timeout ? T : 5);
    sw_start(name);
    domain_ready_i = '0;
    for (int n = 1; n <= coll; n++) begin
      sw_rst_req_i = (n == coll);
      domain_ready_i[0] = !use_timeout && (n >= coll);
      @(posedge clk_i);
      #1;
      if (n == coll - 1) begin
        checks++;
        if (domain_rst_no !== 3'b001) begin
          errors++;
          $display("FAIL %s pre_collision: got %b expected 001", name, domain_rst_no);
        end
      end
    end
    checks++;
    if (domain_rst_no !== 3'b000 || timeout_err_o !== 1'b0 || stage_o !== 2'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s collision: got rst_n=%b to=%b stage=%0d busy=%b expected 000/0/0/1",
               name, domain_rst_no, timeout_err_o, stage_o, busy_o);
    end
    run_seq(name, SWH, 0, 0, 0, 1, 0);
  endtask

  // 5 ns rst_ni pulse while in STEP after domain 0, then a request in HOLD.
  task automatic test_async_reset();
    sw_start("async");
    for (int n = 1; n <= SWH + 4; n++) begin
      sw_rst_req_i = 1'b0;
      domain_ready_i = 3'b111;
      @(posedge clk_i);
      #1;
    end
    checks++;
    if (domain_rst_no !== 3'b001) begin
      errors++;
      $display("FAIL async pre_reset: got %b expected 001", domain_rst_no);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (domain_rst_no !== 3'b000 || seq_done_o !== 1'b0 || busy_o !== 1'b1 || stage_o !== 2'd0) begin
      errors++;
      $display("FAIL async in_pulse: got rst_n=%b done=%b busy=%b stage=%0d expected 000/0/1/0",
               domain_rst_no, seq_done_o, busy_o, stage_o);
    end
    #4;
    rst_ni = 1'b1;
    run_seq("after_async", H, 0, 0, 0, 5, 5);
  endtask

  task automatic test_random();
    int d [N];
    int len, r;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < N; k++) begin
        r = int'($urandom_range(0, 3));
        case (r)
          0: d[k] = 0;
          1: d[k] = int'($urandom_range(1, 8));
          2: d[k] = int'($urandom_range(T - 2, T + 2));
          default: d[k] = NEVER;
        endcase
      end
      len = int'($urandom_range(1, 12));
      sw_start($sformatf("random%0d", it));
      run_seq($sformatf("random%0d", it), SWH, d[0], d[1], d[2], 1, len - 1);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_ready_delay();
    test_timeout();
    test_sw_reset();
    test_sw_wins(1'b0);
    test_sw_wins(1'b1);
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
